// File: rtl/data_memory.sv
// data_memory: 256-bit line memory responder for the dcache memory port; optional DMEM_PROTOCOL_CHECK_EN checker.
// Latency: ack_o pulses in the cycle after capture edge + LATENCY; one request per LATENCY+2 cycles.
// Backpressure: requester holds enable_i until ack_o; request inputs are ignored while busy.
module data_memory #(
    parameter int MEM_LINES = 512,
    parameter int LATENCY   = 10
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         enable_i,
    input  logic         write_i,
    input  logic [31:0]  addr_i,
    input  logic [255:0] data_i,
    output logic         ack_o,
    output logic [255:0] data_o
`ifdef DMEM_PROTOCOL_CHECK_EN
    ,
    output logic         proto_err_o
`endif
);
    localparam int IDX_W = $clog2(MEM_LINES);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [26:0]      req_addr;   // whole line address so the checker sees upper-bit changes
    logic             req_write;
    logic [255:0]     req_data;
    logic [255:0]     mem [MEM_LINES];
    logic             capture;
    logic             access;
    logic [IDX_W-1:0] idx;
    logic             unused_bits;

    assign idx         = req_addr[IDX_W-1:0];
    assign unused_bits = ^{addr_i[4:0], req_addr};

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        access    = 1'b0;
        case (state)
            IDLE: begin
                if (enable_i) begin
                    capture   = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    access    = 1'b1;
                    state_nxt = ACK;
                end
            end
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            cnt    <= '0;
            ack_o  <= 1'b0;
            data_o <= '0;
        end else begin
            state <= state_nxt;
            ack_o <= access;
            if (capture) begin
                cnt <= CNT_LOAD;
            end else if (state == BUSY && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (access && !req_write) begin
                data_o <= mem[idx];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (capture) begin
            req_addr  <= addr_i[31:5];
            req_write <= write_i;
            req_data  <= data_i;
        end
    end

    // Array has no reset; a reset during BUSY must drop the pending write.
    always_ff @(posedge clk_i) begin
        if (access && req_write && !rst_i) begin
            mem[idx] <= req_data;
        end
    end

`ifdef DMEM_PROTOCOL_CHECK_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            proto_err_o <= 1'b0;
        end else if (state == BUSY &&
                     (!enable_i || write_i != req_write || addr_i[31:5] != req_addr ||
                      (write_i && data_i != req_data))) begin
            proto_err_o <= 1'b1;
        end
    end
`endif

endmodule
